// File: rtl/led_pattern_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_ctrl_if
// Brief    : Control / status bundle between button logic and the LED
//            pattern sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface led_pattern_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;   // single-cycle pulse
  logic             stop;    // single-cycle pulse
  logic             pause;   // single-cycle pulse, toggles RUN/PAUSE
  logic [1:0]       mode;    // pattern select, sampled on start
  logic [1:0]       speed;   // rate select, sampled on start
  logic [WIDTH-1:0] led;     // registered pattern output
  logic             busy;    // RUN or PAUSE
  logic             step;    // one-cycle pulse per pattern advance
  logic             wrap;    // one-cycle pulse when pattern returns to seed

  // Controller side: issues commands, observes the LEDs
  modport master (
    output start, stop, pause, mode, speed,
    input  led, busy, step, wrap
  );

  // Sequencer side
  modport slave (
    input  start, stop, pause, mode, speed,
    output led, busy, step, wrap
  );
endinterface
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_ctrl
// Brief    : Runs an LED shift register in one of four patterns
//            (rotate-left, rotate-right, ping-pong, fill/drain) at a
//            programmable step rate, with start/stop/pause control and
//            step/wrap strobes.
// Revision : 1.0  initial release
// ============================================================================
module led_pattern_ctrl #(
  parameter int BASE_DIV = 50000000,  // cycles per step at speed 0, >= 2
  parameter int WIDTH    = 8          // fixed LED width
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  led_pattern_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Prescaler must hold up to (BASE_DIV << 3) - 1
  localparam int c_CW = $clog2(BASE_DIV * 8);
  localparam logic [c_CW-1:0] c_LAST0 = c_CW'(BASE_DIV * 1 - 1);
  localparam logic [c_CW-1:0] c_LAST1 = c_CW'(BASE_DIV * 2 - 1);
  localparam logic [c_CW-1:0] c_LAST2 = c_CW'(BASE_DIV * 4 - 1);
  localparam logic [c_CW-1:0] c_LAST3 = c_CW'(BASE_DIV * 8 - 1);

  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONES = '1;
  localparam logic [WIDTH-1:0] c_LSB  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       r_speed;
  logic [c_CW-1:0]  r_presc;
  logic [WIDTH-1:0] r_led;
  logic             r_dir;     // 0 = moving left, 1 = moving right
  logic             r_phase;   // 0 = filling, 1 = draining
  logic             r_step;
  logic             r_wrap;

  logic [1:0]       w_mode_nxt;
  logic [1:0]       w_speed_nxt;
  logic [c_CW-1:0]  w_presc_nxt;
  logic [WIDTH-1:0] w_led_nxt;
  logic             w_dir_nxt;
  logic             w_phase_nxt;
  logic             w_step_nxt;
  logic             w_wrap_nxt;

  logic [c_CW-1:0]  w_last;
  logic [WIDTH-1:0] w_adv_led;
  logic             w_adv_dir;
  logic             w_adv_phase;

  // Starting value of each pattern; also the value whose reappearance marks a wrap
  function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
    case (m)
      2'd0:    seed_of = c_LSB;
      2'd1:    seed_of = c_MSB;
      2'd2:    seed_of = c_LSB;
      default: seed_of = c_ZERO;
    endcase
  endfunction

  // Terminal prescaler count for the latched speed
  always_comb begin
    w_last = c_LAST0;
    case (r_speed)
      2'd0:    w_last = c_LAST0;
      2'd1:    w_last = c_LAST1;
      2'd2:    w_last = c_LAST2;
      default: w_last = c_LAST3;
    endcase
  end

  // Pattern value, direction and phase after one advance of the latched mode
  always_comb begin
    w_adv_led   = r_led;
    w_adv_dir   = r_dir;
    w_adv_phase = r_phase;
    case (r_mode)
      2'd0: w_adv_led = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
      2'd1: w_adv_led = {r_led[0], r_led[WIDTH-1:1]};
      2'd2: begin
        // Direction flips on the edge the end bit is reached so ends show once
        if (!r_dir) begin
          w_adv_led = {r_led[WIDTH-2:0], 1'b0};
          if (w_adv_led == c_MSB) w_adv_dir = 1'b1;
        end else begin
          w_adv_led = {1'b0, r_led[WIDTH-1:1]};
          if (w_adv_led == c_LSB) w_adv_dir = 1'b0;
        end
      end
      default: begin
        if (!r_phase) begin
          w_adv_led = {r_led[WIDTH-2:0], 1'b1};
          if (w_adv_led == c_ONES) w_adv_phase = 1'b1;
        end else begin
          w_adv_led = {r_led[WIDTH-2:0], 1'b0};
          if (w_adv_led == c_ZERO) w_adv_phase = 1'b0;
        end
      end
    endcase
  end

  // Next state and datapath; command priority is stop > start > pause
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_speed_nxt = r_speed;
    w_presc_nxt = r_presc;
    w_led_nxt   = r_led;
    w_dir_nxt   = r_dir;
    w_phase_nxt = r_phase;
    w_step_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (bus.stop) begin
      w_state_nxt = ST_IDLE;
      w_led_nxt   = c_ZERO;
      w_presc_nxt = '0;
    end else if (bus.start) begin
      // Full restart from any state, pause in the same cycle is overridden
      w_state_nxt = ST_RUN;
      w_mode_nxt  = bus.mode;
      w_speed_nxt = bus.speed;
      w_led_nxt   = seed_of(bus.mode);
      w_presc_nxt = '0;
      w_dir_nxt   = 1'b0;
      w_phase_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.pause) begin
            // Freeze prescaler as-is so resume neither gains nor loses a step
            w_state_nxt = ST_PAUSE;
          end else if (r_presc == w_last) begin
            w_presc_nxt = '0;
            w_led_nxt   = w_adv_led;
            w_dir_nxt   = w_adv_dir;
            w_phase_nxt = w_adv_phase;
            w_step_nxt  = 1'b1;
            w_wrap_nxt  = (w_adv_led == seed_of(r_mode));
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.pause) w_state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pattern datapath and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= 2'd0;
      r_speed <= 2'd0;
      r_presc <= '0;
      r_led   <= c_ZERO;
      r_dir   <= 1'b0;
      r_phase <= 1'b0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_speed <= w_speed_nxt;
      r_presc <= w_presc_nxt;
      r_led   <= w_led_nxt;
      r_dir   <= w_dir_nxt;
      r_phase <= w_phase_nxt;
      r_step  <= w_step_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.led  = r_led;
  assign bus.busy = (r_state != ST_IDLE);
  assign bus.step = r_step;
  assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_ctrl
// Brief    : Scoreboard bench for led_pattern_ctrl with BASE_DIV = 4.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic       wrap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  exp_t q[$];

  led_pattern_ctrl_if #(.WIDTH(8)) ifc ();

  led_pattern_ctrl #(.BASE_DIV(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Hand-computed step sequences (values after each step)
  logic [7:0] SEQ0 [9]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] SEQ2 [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] SEQ3 [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                            8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [7:0] l, input logic w);
    exp_t e;
    e.cyc  = c;
    e.led  = l;
    e.wrap = w;
    q.push_back(e);
  endtask

  // Advance to 1 time unit after the edge that makes cyc == k
  task automatic goto_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [1:0] s, output int e0);
    ifc.start = 1'b1;
    ifc.mode  = m;
    ifc.speed = s;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    e0 = cyc;
    // Scramble selects: latched values must be unaffected
    ifc.mode  = ~m;
    ifc.speed = ~s;
  endtask

  task automatic pulse_stop();
    ifc.stop = 1'b1;
    @(posedge clk);
    #1;
    ifc.stop = 1'b0;
  endtask

  task automatic pulse_pause();
    ifc.pause = 1'b1;
    @(posedge clk);
    #1;
    ifc.pause = 1'b0;
  endtask

  // Monitor: every step strobe is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("wrap_implies_step", int'(ifc.wrap & ~ifc.step), 0);
      if (q.size() > 0 && cyc > q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_step: got none expected led %0h at cycle %0d", q[0].led, q[0].cyc);
        void'(q.pop_front());
      end
      if (ifc.step) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: got step led %0h expected no step (cycle %0d)", ifc.led, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("step_cycle", cyc, e.cyc);
          chk("step_led", int'(ifc.led), int'(e.led));
          chk("step_wrap", int'(ifc.wrap), int'(e.wrap));
          chk("step_busy", int'(ifc.busy), 1);
        end
      end
    end
  end

  initial begin
    int e0;
    int r;
    errors = 0;
    checks = 0;
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    ifc.pause = 1'b0;
    ifc.mode  = 2'd0;
    ifc.speed = 2'd0;
    rst_n     = 1'b0;

    // Reset state
    #2;
    chk("rst_led", int'(ifc.led), 0);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_step", int'(ifc.step), 0);
    chk("rst_wrap", int'(ifc.wrap), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_led", int'(ifc.led), 0);
    chk("idle_busy", int'(ifc.busy), 0);

    // Mode 0, speed 0: rotate left, P = 4
    do_start(2'd0, 2'd0, e0);
    for (int n = 0; n < 9; n++) push_exp(e0 + (n + 1) * 4, SEQ0[n], n == 7);
    @(negedge clk);
    chk("m0_seed", int'(ifc.led), 8'h01);
    chk("m0_busy", int'(ifc.busy), 1);
    goto_edge(e0 + 37);
    @(negedge clk);
    chk("m0_drained", q.size(), 0);
    pulse_stop();
    @(negedge clk);
    chk("m0_stop_led", int'(ifc.led), 0);
    chk("m0_stop_busy", int'(ifc.busy), 0);

    // Mode 2, speed 1: ping-pong, P = 8
    do_start(2'd2, 2'd1, e0);
    for (int n = 0; n < 15; n++) push_exp(e0 + (n + 1) * 8, SEQ2[n], n == 13);
    @(negedge clk);
    chk("m2_seed", int'(ifc.led), 8'h01);
    goto_edge(e0 + 121);
    @(negedge clk);
    chk("m2_drained", q.size(), 0);
    pulse_stop();

    // Mode 3, speed 0: fill/drain, P = 4
    do_start(2'd3, 2'd0, e0);
    for (int n = 0; n < 17; n++) push_exp(e0 + (n + 1) * 4, SEQ3[n], n == 15);
    @(negedge clk);
    chk("m3_seed", int'(ifc.led), 8'h00);
    chk("m3_busy", int'(ifc.busy), 1);
    goto_edge(e0 + 69);
    @(negedge clk);
    chk("m3_drained", q.size(), 0);
    pulse_stop();

    // Mode 1 with pause while prescaler = 1
    do_start(2'd1, 2'd0, e0);
    push_exp(e0 + 4, 8'h40, 1'b0);
    @(negedge clk);
    chk("m1_seed", int'(ifc.led), 8'h80);
    goto_edge(e0 + 5);
    pulse_pause();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("pause_led", int'(ifc.led), 8'h40);
      chk("pause_step", int'(ifc.step), 0);
      chk("pause_busy", int'(ifc.busy), 1);
    end
    @(posedge clk);
    #1;
    pulse_pause();
    r = cyc;
    push_exp(r + 3, 8'h20, 1'b0);
    goto_edge(r + 4);
    @(negedge clk);
    chk("resume_drained", q.size(), 0);
    pulse_stop();

    // Same-cycle stop + start while running
    do_start(2'd0, 2'd0, e0);
    push_exp(e0 + 4, 8'h02, 1'b0);
    goto_edge(e0 + 5);
    ifc.stop  = 1'b1;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.stop  = 1'b0;
    ifc.start = 1'b0;
    @(negedge clk);
    chk("stopstart_led", int'(ifc.led), 0);
    chk("stopstart_busy", int'(ifc.busy), 0);
    goto_edge(cyc + 10);
    @(negedge clk);
    chk("stopstart_idle", int'(ifc.busy), 0);
    chk("stopstart_drained", q.size(), 0);

    // Same-cycle start + pause from PAUSE: fresh restart into RUN
    do_start(2'd1, 2'd0, e0);
    goto_edge(e0 + 2);
    pulse_pause();
    goto_edge(e0 + 6);
    @(negedge clk);
    chk("paused_led", int'(ifc.led), 8'h80);
    chk("paused_busy", int'(ifc.busy), 1);
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.pause = 1'b1;
    ifc.mode  = 2'd0;
    ifc.speed = 2'd0;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.pause = 1'b0;
    r = cyc;
    push_exp(r + 4, 8'h02, 1'b0);
    @(negedge clk);
    chk("startpause_led", int'(ifc.led), 8'h01);
    chk("startpause_busy", int'(ifc.busy), 1);
    goto_edge(r + 5);
    @(negedge clk);
    chk("startpause_drained", q.size(), 0);
    pulse_stop();

    // Pause in IDLE is ignored
    pulse_pause();
    @(negedge clk);
    chk("idlepause_led", int'(ifc.led), 0);
    chk("idlepause_busy", int'(ifc.busy), 0);
    goto_edge(cyc + 8);
    @(negedge clk);
    chk("idlepause_busy_late", int'(ifc.busy), 0);

    // Asynchronous reset mid-pattern
    do_start(2'd0, 2'd0, e0);
    for (int n = 0; n < 4; n++) push_exp(e0 + (n + 1) * 4, SEQ0[n], 1'b0);
    goto_edge(e0 + 17);
    chk("prerst_led", int'(ifc.led), 8'h10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_led", int'(ifc.led), 0);
    chk("arst_busy", int'(ifc.busy), 0);
    chk("arst_step", int'(ifc.step), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    goto_edge(cyc + 12);
    @(negedge clk);
    chk("postrst_led", int'(ifc.led), 0);
    chk("postrst_busy", int'(ifc.busy), 0);
    chk("postrst_drained", q.size(), 0);
    do_start(2'd1, 2'd0, e0);
    @(negedge clk);
    chk("postrst_start_led", int'(ifc.led), 8'h80);
    pulse_stop();

    @(negedge clk);
    chk("final_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Sequencer for the 8-bit LED shift datapath: runs the register in one of four patterns at a programmable step rate.
- Provides start/stop/pause control.
- Emits a one-cycle step strobe on every pattern advance and a wrap strobe at the end of each full pattern period.
- Sits between board-level push-button/switch logic (already synchronised and edge-detected into single-cycle pulses) and the LED pins.

Parameters:
- BASE_DIV, default 50000000: clock cycles per step at speed 0. Minimum value 2; the bench uses 4.
- WIDTH, fixed at 8: LED vector width. Do not override.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: latch mode/speed, seed the pattern, enter RUN.
- stop  in  1  single-cycle pulse: return to IDLE, blank LEDs.
- pause  in  1  single-cycle pulse: toggle RUN<->PAUSE.
- mode  in  2  pattern select, sampled only on start: 0 rotate-left, 1 rotate-right, 2 ping-pong, 3 fill/drain.
- speed  in  2  rate select, sampled only on start: step period P = BASE_DIV << speed cycles.
- led  out  8  pattern output, registered.
- busy  out  1  high in RUN or PAUSE.
- step  out  1  one-cycle pulse, coincident with each led update.
- wrap  out  1  one-cycle pulse, on the step that returns led to its seed value.

Behaviour:
- Reset (async, rst_n=0) sets all of the following immediately and holds them until release:
  - state=IDLE, led=8'h00, busy=0, step=0, wrap=0.
  - prescaler=0, latched mode=0, latched speed=0, ping-pong direction=left, fill phase=fill.
- FSM states are IDLE, RUN and PAUSE. Input priority each cycle is stop > start > pause.
  - stop (any state): next edge goes to IDLE; led=0, prescaler=0, step/wrap=0.
  - start (any state, no stop): next edge goes to RUN. That edge also latches mode/speed, loads the seed, clears the prescaler, sets direction=left and phase=fill. A start in RUN or PAUSE is a full restart.
  - pause: RUN->PAUSE, PAUSE->RUN. Ignored in IDLE.
- Seeds:
  - mode0: 8'h01.
  - mode1: 8'h80.
  - mode2: 8'h01.
  - mode3: 8'h00.
- Prescaler:
  - Counts 0..P-1 in RUN only.
  - When it is P-1, the next edge wraps it to 0, advances led and asserts step for one cycle.
  - The first advance therefore occurs exactly P edges after the start edge.
  - In PAUSE the prescaler and led are frozen. On resume, counting continues from the frozen value, with no extra or lost step.
- Pattern advance per step:
  - mode0: led <= {led[6:0],led[7]}. Period is 8 steps; wrap on 8'h80->8'h01.
  - mode1: led <= {led[0],led[7:1]}. Period is 8 steps; wrap on 8'h01->8'h80.
  - mode2 (single hot bit bouncing): with direction left, shift left; on reaching 8'h80, direction becomes right. With direction right, shift right; on reaching 8'h01, direction becomes left. The direction flips on the same edge the end bit is reached, so each end value is shown for one step only. Sequence: 01,02,…,80,40,…,01. Period is 14 steps; wrap on 02->01.
  - mode3: in fill phase, led <= {led[6:0],1'b1}; on reaching 8'hFF, phase becomes drain. In drain phase, led <= {led[6:0],1'b0}; on reaching 8'h00, phase becomes fill. Period is 16 steps; wrap on 8'h80->8'h00.
- wrap is asserted only together with step. step and wrap are 0 in IDLE and PAUSE.
- Changes on mode or speed while running have no effect until the next start.
- In the same cycle, start+pause gives a restart into RUN (not PAUSE), and stop+start gives IDLE.
- Reset asserted mid-pattern clears everything asynchronously. After release the block stays in IDLE with led=0 until a start pulse.

Test Plan (BASE_DIV=4):
- Reset, then start with mode=0, speed=0: led=01 on the edge after start; led=02 with step=1 4 cycles later; after 8 steps led=01 with wrap=1; busy=1 throughout.
- mode=2, speed=1 (P=8): led follows 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01, one step every 8 cycles. wrap=1 only on the final 01. Direction flips at 80 and 01 without repeating them.
- mode=3, speed=0: led goes 00,01,03,…,FF,FE,FC,…,80,00; wrap on 80->00 after 16 steps, then the fill sequence repeats.
- mode=1 run, pause after 6 cycles (prescaler=1 after the first step): led frozen at 40 and step=0 for 20 cycles. After resume, the next step (led=20) arrives after exactly 3 more cycles.
- Same-cycle stop+start while running: goes to IDLE, led=00, busy=0. Same-cycle start+pause from PAUSE: goes to RUN with a fresh seed. pause in IDLE: no change.
- rst_n pulled low mid-step in mode0 at led=10: led=00 and busy=0 immediately, without waiting for a clock edge. After release, no activity until start.
